// File: rtl/simple_uart_rx.sv
// 8N1 serial receiver: two-flop line synchroniser, start-edge detect, mid-bit sampling,
// one-cycle valid / frame-error strobes.
module simple_uart_rx #(
  parameter int unsigned SYSTEM_FREQ = 50_000_000,
  parameter int unsigned BAUD_RATE   = 9600
) (
  input  logic       clock,
  input  logic       arst_n,
  input  logic       rx_bit,
  output logic [7:0] rx_value,
  output logic       rx_value_valid,
  output logic       rx_frame_error,
  output logic       rx_busy
);

  localparam int unsigned P                = SYSTEM_FREQ / BAUD_RATE;
  localparam int unsigned CNT_W            = $clog2(P);
  localparam int unsigned BAUD_COUNTER_MAX = P - 1;
  localparam int unsigned HALF             = (P - 1) / 2;

  // START leaves on the HALF-th cycle after the edge cycle, the counter having been cleared on entry
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_COUNTER_MAX);

  if (P < 4) begin : g_bad_ratio
    $error("simple_uart_rx: SYSTEM_FREQ/BAUD_RATE must be at least 4");
  end

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } state_t;

  state_t           state;
  logic [1:0]       sync_q;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift_q;
  logic             rx_s;

  assign rx_s = sync_q[1];

  // Receive FSM; rx_busy tracks every transition into and out of IDLE
  always_ff @(posedge clock or negedge arst_n) begin
    if (!arst_n) begin
      state          <= IDLE;
      sync_q         <= 2'b11;
      cnt            <= '0;
      bit_idx        <= '0;
      shift_q        <= '0;
      rx_value       <= '0;
      rx_value_valid <= 1'b0;
      rx_frame_error <= 1'b0;
      rx_busy        <= 1'b0;
    end else begin
      sync_q         <= {sync_q[0], rx_bit};
      rx_value_valid <= 1'b0;
      rx_frame_error <= 1'b0;

      case (state)
        IDLE: begin
          cnt <= '0;
          if (!rx_s) begin
            state   <= START;
            rx_busy <= 1'b1;
          end
        end

        START: begin
          if (cnt == CNT_HALF) begin
            cnt <= '0;
            if (rx_s) begin
              // line went back high before mid start bit: treat as a glitch
              state   <= IDLE;
              rx_busy <= 1'b0;
            end else begin
              state   <= DATA;
              bit_idx <= '0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        DATA: begin
          if (cnt == CNT_LAST) begin
            cnt     <= '0;
            shift_q <= {rx_s, shift_q[7:1]};
            if (bit_idx == 3'd7) begin
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        STOP: begin
          if (cnt == CNT_LAST) begin
            cnt <= '0;
            if (rx_s) begin
              rx_value       <= shift_q;
              rx_value_valid <= 1'b1;
              state          <= IDLE;
              rx_busy        <= 1'b0;
            end else begin
              rx_frame_error <= 1'b1;
              state          <= WAIT_IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        WAIT_IDLE: begin
          // a break holds the line low; only its release re-arms start detection
          cnt <= '0;
          if (rx_s) begin
            state   <= IDLE;
            rx_busy <= 1'b0;
          end
        end

        default: begin
          state   <= IDLE;
          cnt     <= '0;
          rx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_simple_uart_rx.sv
// Self-checking bench for simple_uart_rx at 10 clocks per bit; a scoreboard of expected
// receive events is filled from the frame rules and drained by a negedge monitor.
module tb_simple_uart_rx;

  localparam int unsigned SYS_F  = 1_000_000;
  localparam int unsigned BAUD   = 100_000;
  localparam int          CLK_T  = 10;
  localparam int          BIT_T  = 100;

  logic       clock = 1'b0;
  logic       arst_n = 1'b0;
  logic       rx_bit = 1'b1;
  logic [7:0] rx_value;
  logic       rx_value_valid;
  logic       rx_frame_error;
  logic       rx_busy;

  simple_uart_rx #(
    .SYSTEM_FREQ(SYS_F),
    .BAUD_RATE  (BAUD)
  ) dut (
    .clock         (clock),
    .arst_n        (arst_n),
    .rx_bit        (rx_bit),
    .rx_value      (rx_value),
    .rx_value_valid(rx_value_valid),
    .rx_frame_error(rx_frame_error),
    .rx_busy       (rx_busy)
  );

  always #(CLK_T / 2) clock = ~clock;

  typedef struct {
    logic       is_err;
    logic [7:0] val;
  } ev_t;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         bit_t;
    int         hold_t;
    int         idle_t;
    logic       exp_err;
    logic [7:0] exp_val;
  } vec_t;

  ev_t   exp_q[$];
  string tag_q[$];
  int    checks = 0;
  int    errors = 0;
  int    n_valid = 0;
  int    n_err = 0;
  logic  prev_pulse = 1'b0;

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic expect_ev(input logic is_err, input logic [7:0] val, input string tag);
    ev_t e;
    e.is_err = is_err;
    e.val    = val;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  // Serial frame: start, 8 data LSB first, stop, optional extra low time, then idle high
  task automatic send_frame(input logic [7:0] d, input logic stop, input int bit_t, input int hold_t);
    rx_bit = 1'b0;
    #(bit_t);
    for (int i = 0; i < 8; i++) begin
      rx_bit = d[i];
      #(bit_t);
    end
    rx_bit = stop;
    #(bit_t);
    if (hold_t > 0) begin
      rx_bit = 1'b0;
      #(hold_t);
    end
    rx_bit = 1'b1;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n;
    n = 0;
    while (rx_busy && n < budget) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (rx_busy) begin
      errors++;
      $display("FAIL %s: rx_busy still 1 after %0d cycles, expected 0", tag, budget);
    end
  endtask

  // Scoreboard monitor: every strobe must match the oldest expected event
  always @(negedge clock) begin
    ev_t   e;
    string t;
    if (!arst_n) begin
      prev_pulse = 1'b0;
    end else begin
      if (rx_value_valid || rx_frame_error) begin
        if (rx_value_valid) n_valid++;
        if (rx_frame_error) n_err++;
        checks++;
        if (rx_value_valid && rx_frame_error) begin
          errors++;
          $display("FAIL strobe_overlap: valid=1 error=1, expected at most one");
        end
        checks++;
        if (prev_pulse) begin
          errors++;
          $display("FAIL strobe_width: strobe high 2 cycles in a row, expected 1");
        end
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event: valid=%0b error=%0b value=0x%02h, expected none",
                   rx_value_valid, rx_frame_error, rx_value);
        end else begin
          e = exp_q.pop_front();
          t = tag_q.pop_front();
          if (e.is_err !== rx_frame_error || (!e.is_err && rx_value !== e.val)) begin
            errors++;
            $display("FAIL event_%s: got error=%0b value=0x%02h, expected error=%0b value=0x%02h",
                     t, rx_frame_error, rx_value, e.is_err, e.val);
          end
        end
      end
      prev_pulse = rx_value_valid || rx_frame_error;
    end
  end

  initial begin
    #(4_000_000);
    errors++;
    $display("FAIL timeout: simulation still running, expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin
    vec_t       vecs[7];
    int         lat;
    logic       found;
    int         busy_cnt;
    int         v0;
    int         e0;
    logic [7:0] d;
    logic       bad;
    logic [7:0] model_last;

    // back-to-back 0x00/0xFF, skewed 0x55 both ways, a bad stop bit, then recovery
    vecs[0] = '{8'h00, 1'b1, 100, 0,  0,   1'b0, 8'h00};
    vecs[1] = '{8'hFF, 1'b1, 100, 0,  0,   1'b0, 8'hFF};
    vecs[2] = '{8'h55, 1'b1, 104, 0,  50,  1'b0, 8'h55};
    vecs[3] = '{8'h55, 1'b1, 96,  0,  0,   1'b0, 8'h55};
    vecs[4] = '{8'hC3, 1'b0, 100, 50, 200, 1'b1, 8'h00};
    vecs[5] = '{8'h81, 1'b1, 100, 0,  0,   1'b0, 8'h81};
    vecs[6] = '{8'h7E, 1'b1, 100, 0,  30,  1'b0, 8'h7E};

    // reset state
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("reset_rx_value", rx_value, 0);
    chk("reset_valid", rx_value_valid, 0);
    chk("reset_error", rx_frame_error, 0);
    chk("reset_busy", rx_busy, 0);
    @(posedge clock);
    #1 arst_n = 1'b1;
    repeat (5) @(posedge clock);
    #1;

    // single frame 0xA5 and its latency from the falling start edge
    expect_ev(1'b0, 8'hA5, "t1_a5");
    lat   = 0;
    found = 1'b0;
    fork
      send_frame(8'hA5, 1'b1, BIT_T, 0);
      begin
        while (!found && lat < 200) begin
          @(posedge clock);
          lat++;
          #1;
          if (rx_value_valid) found = 1'b1;
        end
      end
    join
    chk("t1_latency", lat, 97);
    wait_idle(50, "t1_idle");
    chk("t1_value", rx_value, 8'hA5);
    model_last = 8'hA5;

    // short low glitch on an idle line
    repeat (20) @(posedge clock);
    #1 rx_bit = 1'b0;
    busy_cnt = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clock);
      #1;
      if (i == 2) rx_bit = 1'b1;
      busy_cnt += int'(rx_busy);
    end
    chk("t2_busy_bounded", int'(busy_cnt > 0 && busy_cnt <= 6), 1);
    chk("t2_busy_end", rx_busy, 0);

    // bad stop bit followed by a 30-cycle break
    @(posedge clock);
    #1;
    expect_ev(1'b1, 8'h00, "t3_err");
    send_frame(8'h3C, 1'b0, BIT_T, 30 * CLK_T);
    chk("t3_busy_while_low", rx_busy, 1);
    wait_idle(20, "t3_idle");
    chk("t3_value_kept", rx_value, 8'hA5);

    // table of frames, applied back to back where idle_t is 0
    repeat (10) @(posedge clock);
    #1;
    for (int i = 0; i < 7; i++) begin
      expect_ev(vecs[i].exp_err, vecs[i].exp_val, $sformatf("vec%0d", i));
      send_frame(vecs[i].data, vecs[i].stop, vecs[i].bit_t, vecs[i].hold_t);
      if (vecs[i].idle_t > 0) #(vecs[i].idle_t);
      if (!vecs[i].exp_err) model_last = vecs[i].exp_val;
    end
    wait_idle(50, "vec_idle");
    chk("vec_last_value", rx_value, model_last);

    // asynchronous reset in the middle of a data bit of 0x12
    repeat (10) @(posedge clock);
    #1 rx_bit = 1'b0;
    #(BIT_T);
    rx_bit = 1'b0;
    #(BIT_T);
    rx_bit = 1'b1;
    #(BIT_T);
    rx_bit = 1'b0;
    #(BIT_T / 2);
    arst_n = 1'b0;
    #3;
    chk("t5_rst_value", rx_value, 0);
    chk("t5_rst_valid", rx_value_valid, 0);
    chk("t5_rst_error", rx_frame_error, 0);
    chk("t5_rst_busy", rx_busy, 0);
    rx_bit = 1'b1;
    repeat (3) @(posedge clock);
    #1 arst_n = 1'b1;
    repeat (20) @(posedge clock);
    #1;
    chk("t5_post_rst_busy", rx_busy, 0);
    expect_ev(1'b0, 8'h5A, "t5_5a");
    send_frame(8'h5A, 1'b1, BIT_T, 0);
    wait_idle(50, "t5_idle");
    chk("t5_value", rx_value, 8'h5A);
    model_last = 8'h5A;

    // random frames: good ones deliver their byte, a 0 stop bit gives one error
    repeat (5) @(posedge clock);
    #1;
    for (int i = 0; i < 40; i++) begin
      d   = 8'($urandom);
      bad = ($urandom_range(0, 4) == 0);
      if (bad) begin
        expect_ev(1'b1, 8'h00, $sformatf("rand%0d", i));
        send_frame(d, 1'b0, int'($urandom_range(98, 102)), int'($urandom_range(0, 200)));
        #(100 + int'($urandom_range(0, 200)));
      end else begin
        expect_ev(1'b0, d, $sformatf("rand%0d", i));
        model_last = d;
        send_frame(d, 1'b1, int'($urandom_range(98, 102)), 0);
        #(int'($urandom_range(0, 250)));
      end
    end
    wait_idle(50, "rand_idle");
    chk("rand_last_value", rx_value, model_last);

    // loopback-style stream of every byte value, no idle between frames
    repeat (3) @(negedge clock);
    v0 = n_valid;
    e0 = n_err;
    @(posedge clock);
    #1;
    for (int i = 0; i < 256; i++) begin
      expect_ev(1'b0, 8'(i), $sformatf("loop%0d", i));
      send_frame(8'(i), 1'b1, BIT_T, 0);
    end
    wait_idle(50, "loop_idle");
    repeat (3) @(negedge clock);
    chk("loop_valid_count", n_valid - v0, 256);
    chk("loop_error_count", n_err - e0, 0);
    chk("loop_last_value", rx_value, 8'hFF);

    repeat (5) @(negedge clock);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
